// File: rtl/memory_arbiter.sv
// Two-requester to one-port memory arbiter: instruction fetch and load/store share one memory.
// Tie rule selectable: define ARBITER_ROUND_ROBIN_EN for round robin, otherwise data port wins ties.
module memory_arbiter #(
   parameter int ADDRESS_WIDTH = 10,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      i_req,
   input  logic [ADDRESS_WIDTH-1:0]  i_addr,
   output logic [DATA_WIDTH-1:0]     i_rdata,
   output logic                      i_ack,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
   input  logic [ADDRESS_WIDTH-1:0]  d_addr,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   output logic                      d_ack,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
   output logic [ADDRESS_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_ready,
   output logic                      grant,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state;
   logic   pick_d;

   // grant doubles as the last-grant record: it only changes on a new grant
   always_comb begin
      pick_d = d_req;
      if (i_req && d_req) begin
`ifdef ARBITER_ROUND_ROBIN_EN
         pick_d = ~grant;
`else
         pick_d = 1'b1;
`endif
      end
   end

   // mem_* outputs are the latched request registers, so requester changes never reach memory mid-access
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wstrb <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         grant     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  grant   <= pick_d;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ACCESS;
                  if (pick_d) begin
                     mem_addr  <= d_addr;
                     mem_we    <= d_we;
                     mem_wstrb <= d_we ? d_wstrb : '0;
                     mem_wdata <= d_wdata;
                  end else begin
                     mem_addr  <= i_addr;
                     mem_we    <= 1'b0;
                     mem_wstrb <= '0;
                     mem_wdata <= '0;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
                  if (grant) begin
                     d_ack <= 1'b1;
                     if (!mem_we) d_rdata <= mem_rdata;
                  end else begin
                     i_ack <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus queues expected accesses/acks, monitors compare.
// Tie expectations follow ARBITER_ROUND_ROBIN_EN when defined.
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [9:0]  i_addr = '0, d_addr = '0;
   logic [3:0]  d_wstrb = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_req, mem_we, mem_ready, grant, busy;
   logic [3:0]  mem_wstrb;
   logic [9:0]  mem_addr;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   memory_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant(grant), .busy(busy)
   );

   // memory model: word array, programmable wait states per access
   logic [31:0] mem [0:255];
   int wait_cfg = 0;
   int wcnt = 0;

   assign mem_ready = mem_req && (wcnt >= wait_cfg);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge CLK) begin
      if (!mem_req || mem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (!reset) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'hA5A5_0000 + 32'(k);
         mem[4]  <= 32'h0050_0093;
         mem[50] <= 32'h1122_3344;
      end else if (mem_req && mem_ready && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   typedef struct {logic port; logic [31:0] rdata;} resp_t;
   typedef struct {logic [9:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} acc_t;
   resp_t resp_q[$];
   acc_t  acc_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event required none", name);
   endtask

   task automatic expect_op(input logic port, input logic we, input logic [9:0] addr,
                            input logic [3:0] strb, input logic [31:0] wdata,
                            input logic [31:0] rdata);
      acc_t  a;
      resp_t r;
      a.addr = addr; a.we = we; a.strb = we ? strb : 4'b0; a.wdata = wdata;
      acc_q.push_back(a);
      r.port = port; r.rdata = rdata;
      resp_q.push_back(r);
   endtask

   task automatic check_access();
      acc_t a;
      if (acc_q.size() == 0) fail_now("unexpected memory access");
      else begin
         a = acc_q.pop_front();
         chk("mem_addr", 64'(mem_addr), 64'(a.addr));
         chk("mem_we", 64'(mem_we), 64'(a.we));
         chk("mem_wstrb", 64'(mem_wstrb), 64'(a.strb));
         if (a.we) chk("mem_wdata", 64'(mem_wdata), 64'(a.wdata));
      end
   endtask

   task automatic check_ack();
      resp_t r;
      chk("acks exclusive", 64'(i_ack & d_ack), 64'(0));
      if (resp_q.size() == 0) fail_now("unexpected ack");
      else begin
         r = resp_q.pop_front();
         chk("ack port", 64'(d_ack), 64'(r.port));
         chk("ack rdata", 64'(r.port ? d_rdata : i_rdata), 64'(r.rdata));
      end
   endtask

   logic       prev_req = 1'b0;
   logic [9:0] prev_addr = '0;
   logic [3:0] prev_strb = '0;

   always @(negedge CLK) begin
      if (mem_req && prev_req) begin
         chk("mem_addr stable", 64'(mem_addr), 64'(prev_addr));
         chk("mem_wstrb stable", 64'(mem_wstrb), 64'(prev_strb));
      end
      prev_req  <= mem_req;
      prev_addr <= mem_addr;
      prev_strb <= mem_wstrb;
      if (mem_req && mem_ready) check_access();
      if (i_ack || d_ack) check_ack();
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(input logic port, input int exp_lat, input string name,
                           output int req_cycles);
      int n = 0;
      req_cycles = 0;
      do begin
         tick();
         n++;
         if (mem_req) req_cycles++;
      end while (!(port ? d_ack : i_ack) && n < 40);
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic do_op(input logic port, input logic we, input logic [9:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input string name);
      int rc;
      wait_cfg = waits;
      expect_op(port, we, addr, strb, wdata, rdata);
      if (port) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wstrb = strb; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      wait_ack(port, waits + 2, name, rc);
      chk({name, " mem_req cycles"}, 64'(rc), 64'(waits + 1));
      chk({name, " grant"}, 64'(grant), 64'(port));
      chk({name, " busy in ack"}, 64'(busy), 64'(1));
      i_req = 1'b0;
      d_req = 1'b0;
      tick();
      chk({name, " busy after"}, 64'(busy), 64'(0));
      chk({name, " ack cleared"}, 64'({i_ack, d_ack}), 64'(0));
   endtask

   int rc, n, ti, td, ci, cd, first, last;

   initial begin
      // reset held with both requests pending
      i_req = 1'b1; i_addr = 10'h010;
      d_req = 1'b1; d_addr = 10'h020; d_we = 1'b0;
      repeat (3) tick();
      chk("rst i_ack", 64'(i_ack), 64'(0));
      chk("rst d_ack", 64'(d_ack), 64'(0));
      chk("rst mem_req", 64'(mem_req), 64'(0));
      chk("rst mem_we", 64'(mem_we), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst mem_wstrb", 64'(mem_wstrb), 64'(0));
      chk("rst mem_addr", 64'(mem_addr), 64'(0));
      chk("rst mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst i_rdata", 64'(i_rdata), 64'(0));
      chk("rst d_rdata", 64'(d_rdata), 64'(0));
      chk("rst grant", 64'(grant), 64'(1));
`ifdef ARBITER_ROUND_ROBIN_EN
      expect_op(1'b0, 1'b0, 10'h010, 4'h0, 32'h0, 32'h0050_0093);
`else
      expect_op(1'b1, 1'b0, 10'h020, 4'h0, 32'h0, 32'hA5A5_0008);
`endif
      reset = 1'b1;
      chk("release mem_req", 64'(mem_req), 64'(0));
      tick();
      chk("first mem_req", 64'(mem_req), 64'(1));
`ifdef ARBITER_ROUND_ROBIN_EN
      wait_ack(1'b0, 1, "reset winner", rc);
`else
      wait_ack(1'b1, 1, "reset winner", rc);
`endif
      i_req = 1'b0; d_req = 1'b0;
      tick();

      do_op(1'b0, 1'b0, 10'h010, 4'h0, 32'h0, 32'h0050_0093, 0, "fetch");
      do_op(1'b1, 1'b0, 10'h020, 4'h0, 32'h0, 32'hA5A5_0008, 0, "load");
      do_op(1'b1, 1'b1, 10'h0C8, 4'b0011, 32'hDEAD_BEEF, 32'hA5A5_0008, 3, "write");
      chk("i_rdata held", 64'(i_rdata), 64'(32'h0050_0093));
      do_op(1'b1, 1'b0, 10'h0C8, 4'b1111, 32'h0, 32'h1122_BEEF, 0, "readback");

      // tie; each port drops its request once acked
      wait_cfg = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
      expect_op(1'b0, 1'b0, 10'h100, 4'h0, 32'h0, 32'hA5A5_0040);
      expect_op(1'b1, 1'b0, 10'h040, 4'h0, 32'h0, 32'hA5A5_0010);
`else
      expect_op(1'b1, 1'b0, 10'h040, 4'h0, 32'h0, 32'hA5A5_0010);
      expect_op(1'b0, 1'b0, 10'h100, 4'h0, 32'h0, 32'hA5A5_0040);
`endif
      i_req = 1'b1; i_addr = 10'h100;
      d_req = 1'b1; d_addr = 10'h040; d_we = 1'b0; d_wstrb = 4'h0;
      n = 0; ti = 0; td = 0;
      while ((ti == 0 || td == 0) && n < 30) begin
         tick();
         n++;
         if (i_ack) begin ti = n; i_req = 1'b0; end
         if (d_ack) begin td = n; d_req = 1'b0; end
      end
`ifdef ARBITER_ROUND_ROBIN_EN
      chk("tie i ack cycle", 64'(ti), 64'(2));
      chk("tie d ack cycle", 64'(td), 64'(5));
`else
      chk("tie d ack cycle", 64'(td), 64'(2));
      chk("tie i ack cycle", 64'(ti), 64'(5));
`endif
      i_req = 1'b0; d_req = 1'b0;
      tick();

      // reset while memory stalls, then reissue
      wait_cfg = 100;
      expect_op(1'b1, 1'b0, 10'h0FC, 4'h0, 32'h0, 32'hA5A5_003F);
      d_req = 1'b1; d_addr = 10'h0FC; d_we = 1'b0;
      tick();
      tick();
      chk("stall mem_req", 64'(mem_req), 64'(1));
      reset = 1'b0;
      #1;
      chk("midrst mem_req", 64'(mem_req), 64'(0));
      chk("midrst busy", 64'(busy), 64'(0));
      chk("midrst grant", 64'(grant), 64'(1));
      chk("midrst acks", 64'({i_ack, d_ack}), 64'(0));
      chk("midrst mem_addr", 64'(mem_addr), 64'(0));
      chk("midrst d_rdata", 64'(d_rdata), 64'(0));
      chk("midrst i_rdata", 64'(i_rdata), 64'(0));
      tick();
      tick();
      wait_cfg = 0;
      reset = 1'b1;
      wait_ack(1'b1, 2, "reissue", rc);
      d_req = 1'b0;
      tick();

      // both requests held continuously for 12 cycles
      wait_cfg = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
      expect_op(1'b0, 1'b0, 10'h100, 4'h0, 32'h0, 32'hA5A5_0040);
      expect_op(1'b1, 1'b0, 10'h040, 4'h0, 32'h0, 32'hA5A5_0010);
      expect_op(1'b0, 1'b0, 10'h100, 4'h0, 32'h0, 32'hA5A5_0040);
      expect_op(1'b1, 1'b0, 10'h040, 4'h0, 32'h0, 32'hA5A5_0010);
`else
      for (int k = 0; k < 4; k++) expect_op(1'b1, 1'b0, 10'h040, 4'h0, 32'h0, 32'hA5A5_0010);
`endif
      i_req = 1'b1; i_addr = 10'h100;
      d_req = 1'b1; d_addr = 10'h040; d_we = 1'b0;
      ci = 0; cd = 0; first = 0; last = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (i_ack) ci++;
         if (d_ack) cd++;
         if (i_ack || d_ack) begin
            if (first == 0) first = c;
            last = c;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();
`ifdef ARBITER_ROUND_ROBIN_EN
      chk("hold i acks", 64'(ci), 64'(2));
      chk("hold d acks", 64'(cd), 64'(2));
`else
      chk("hold i acks", 64'(ci), 64'(0));
      chk("hold d acks", 64'(cd), 64'(4));
`endif
      chk("hold first ack", 64'(first), 64'(2));
      chk("hold last ack", 64'(last), 64'(11));

      repeat (3) tick();
      chk("resp queue drained", 64'(resp_q.size()), 64'(0));
      chk("access queue drained", 64'(acc_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port to one-port arbiter that lets the instruction fetch path and the load/store path share a single unified memory. It sits between the fetch unit and load/store unit on one side and the unified memory on the other. It serialises accesses through a three-state FSM with a req/ack handshake per requester and a req/ready handshake toward memory.

## Interface
- ADDRESS_WIDTH, 10, byte-address width of every address port
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

- CLK  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  ADDRESS_WIDTH  instruction address
- i_rdata  out  DATA_WIDTH  fetched word, registered
- i_ack  out  1  one-cycle completion pulse for instruction port
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  DATA_WIDTH/8  byte enables for writes
- d_addr  in  ADDRESS_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_rdata  out  DATA_WIDTH  load result, registered
- d_ack  out  1  one-cycle completion pulse for data port
- mem_req  out  1  memory access strobe, held until mem_ready
- mem_we  out  1  memory write enable
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables; all-zero on reads
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion for the current access
- grant  out  1  current/last owner: 0 = instruction, 1 = data
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: samples i_req/d_req.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant that port.
  - Both asserted: resolve by the tie rule (see Configuration).
  - On grant: latch the owner's address, we, wstrb and wdata into registers (instruction port: we=0, wstrb=0). Set grant. Go to ACCESS.
- ACCESS: mem_req=1 and mem_* driven from the latched registers.
  - On a cycle with mem_ready=1 and a read: capture mem_rdata into the owner's rdata register only.
  - Either way, go to RESP.
  - mem_ready=0: remain in ACCESS indefinitely; no timeout.
- RESP: owner's ack=1 for exactly this cycle; mem_req=0. Go to IDLE.
- Requester must drop req, or present a new request, in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait. They are not queued separately; a held req is the queue.
- Writes leave d_rdata unchanged. i_rdata/d_rdata hold until that port's next completed read.
- Latched request registers shield memory from requester signal changes during ACCESS.
- Reset mid-operation: FSM to IDLE, in-flight access abandoned with no ack; the requester reissues.

## Timing
- Reset values:
  - i_ack, d_ack, mem_req, mem_we, busy = 0.
  - mem_wstrb, mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - grant = 1.
  - Internal last-grant = data.
- Best case: req sampled in IDLE at cycle 0, mem_req in cycle 1, mem_ready in cycle 1, ack in cycle 2. Latency from req to ack is 2 cycles.
- Each memory wait cycle adds one cycle. Back-to-back requests from one port: one access per 3 cycles minimum.
- The losing port of a tie is served immediately after the winner's RESP. Worst-case wait is one full access plus 1 cycle.
- Acks are mutually exclusive; never both high.

## Configuration
- ARBITER_ROUND_ROBIN_EN defined: on a tie, grant the port not granted last. The last-grant register updates on every grant. The first tie after reset goes to the instruction port.
- Not defined: fixed priority; data port always wins ties. The instruction port may starve under continuous d_req.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold reset=0 with i_req=d_req=1. Required: all outputs at their reset values and no mem_req. Release reset; mem_req rises one cycle later.
- Single fetch: i_req, i_addr=0x010, mem_ready tied 1, mem_rdata=0x00500093. Required: i_ack in cycle 2, i_rdata=0x00500093, d_ack never high.
- Write with wait states: d_we=1, d_addr=0x0C8, d_wstrb=0b0011, d_wdata=0xDEADBEEF, mem_ready low for 3 cycles. Required: mem_req held 4 cycles with stable mem_addr/mem_wstrb, d_ack in cycle 5, d_rdata unchanged.
- Tie, fixed priority (macro undefined): i_req and d_req both held. Required: d_ack precedes each i_ack. With d_req continuous, i_ack never occurs.
- Tie, round robin (macro defined): both held for 12 cycles with mem_ready=1. Required: ack sequence i, d, i, d, one ack every 3 cycles.
- Reset mid-ACCESS: assert reset while mem_ready=0. Required: outputs return to reset values immediately with no ack. After release, the held request reissues and completes.
